// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR access, writeback exception and interrupt signals for csr_file
interface csr_file_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
    output hw_int_in, ipi_int_in,
    input  csr_rvalue, ex_entry, ertn_entry, has_int
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
    input  hw_int_in, ipi_int_in,
    output csr_rvalue, ex_entry, ertn_entry, has_int
  );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - LoongArch CSR file; the timer (TID/TCFG/TVAL/TICLR, IS[11]) is built only with CSR_TIMER_EN
module csr_file #(
  parameter logic [31:0] TID_INIT    = 32'h0,
  parameter logic [31:0] EENTRY_INIT = 32'h1c008000
) (
  input logic       clk,
  input logic       reset,
  csr_file_if.slave bus
);
  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_EENTRY = 14'hc;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
  localparam logic [12:0] LIE_MASK   = 13'h1bff;

  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic        crmd_da;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ipi;
  logic        timer_int;
  logic [12:0] estat_is;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esubcode;
  logic [31:0] era;
  logic [25:0] eentry_va;
  logic [31:0] save [4];

  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        we_crmd;
  logic        we_prmd;
  logic        we_ecfg;
  logic        we_estat;
  logic        we_era;
  logic        we_eentry;
  logic        we_save;

  assign estat_is = {is_ipi, timer_int, 1'b0, is_hw, is_sw};

`ifdef CSR_TIMER_EN
  logic [31:0] tid;
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic        timer_stop;
  logic        timer_fire;
  logic        we_tid;
  logic        we_tcfg;
  logic        ticlr_clr;
`endif

  always_comb begin
    rdata = 32'h0;
    case (bus.csr_num)
      CSR_CRMD:   rdata = {28'h0, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:   rdata = {29'h0, prmd_pie, prmd_pplv};
      CSR_ECFG:   rdata = {19'h0, ecfg_lie};
      CSR_ESTAT:  rdata = {1'b0, estat_esubcode, estat_ecode, 3'h0, estat_is};
      CSR_ERA:    rdata = era;
      CSR_EENTRY: rdata = {eentry_va, 6'h0};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: rdata = save[bus.csr_num[1:0]];
`ifdef CSR_TIMER_EN
      CSR_TID:    rdata = tid;
      CSR_TCFG:   rdata = tcfg;
      CSR_TVAL:   rdata = tval;
`endif
      default:    rdata = 32'h0;
    endcase
  end

  // Merging against the addressed register's current read value gives one shared write word.
  assign wdata          = (rdata & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
  assign bus.csr_rvalue = bus.csr_re ? rdata : 32'h0;

  assign we_crmd   = bus.csr_we && (bus.csr_num == CSR_CRMD);
  assign we_prmd   = bus.csr_we && (bus.csr_num == CSR_PRMD);
  assign we_ecfg   = bus.csr_we && (bus.csr_num == CSR_ECFG);
  assign we_estat  = bus.csr_we && (bus.csr_num == CSR_ESTAT);
  assign we_era    = bus.csr_we && (bus.csr_num == CSR_ERA);
  assign we_eentry = bus.csr_we && (bus.csr_num == CSR_EENTRY);
  assign we_save   = bus.csr_we && (bus.csr_num[13:2] == CSR_SAVE0[13:2]);

  // PLV/IE: exception beats ertn beats software write; DA is only ever written by software.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_plv <= 2'h0;
      crmd_ie  <= 1'b0;
      crmd_da  <= 1'b1;
    end else begin
      if (bus.wb_ex) begin
        crmd_plv <= 2'h0;
        crmd_ie  <= 1'b0;
      end else if (bus.ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (we_crmd) begin
        crmd_plv <= wdata[1:0];
        crmd_ie  <= wdata[2];
      end
      if (we_crmd) begin
        crmd_da <= wdata[3];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prmd_pplv <= 2'h0;
      prmd_pie  <= 1'b0;
    end else if (bus.wb_ex) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
    end else if (we_prmd) begin
      prmd_pplv <= wdata[1:0];
      prmd_pie  <= wdata[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecfg_lie <= 13'h0;
    end else if (we_ecfg) begin
      ecfg_lie <= wdata[12:0] & LIE_MASK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_sw          <= 2'h0;
      is_hw          <= 8'h0;
      is_ipi         <= 1'b0;
      estat_ecode    <= 6'h0;
      estat_esubcode <= 9'h0;
    end else begin
      is_hw  <= bus.hw_int_in;
      is_ipi <= bus.ipi_int_in;
      if (we_estat) begin
        is_sw <= wdata[1:0];
      end
      if (bus.wb_ex) begin
        estat_ecode    <= bus.wb_ecode;
        estat_esubcode <= bus.wb_esubcode;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      era       <= 32'h0;
      eentry_va <= EENTRY_INIT[31:6];
      for (int i = 0; i < 4; i++) begin
        save[i] <= 32'h0;
      end
    end else begin
      if (bus.wb_ex) begin
        era <= bus.wb_pc;
      end else if (we_era) begin
        era <= wdata;
      end
      if (we_eentry) begin
        eentry_va <= wdata[31:6];
      end
      if (we_save) begin
        save[bus.csr_num[1:0]] <= wdata;
      end
    end
  end

`ifdef CSR_TIMER_EN
  assign we_tid     = bus.csr_we && (bus.csr_num == CSR_TID);
  assign we_tcfg    = bus.csr_we && (bus.csr_num == CSR_TCFG);
  assign ticlr_clr  = bus.csr_we && (bus.csr_num == CSR_TICLR) && wdata[0];
  assign timer_fire = !we_tcfg && tcfg[0] && !timer_stop && (tval == 32'h0);

  // A one-shot timer parks at all-ones and stays frozen until TCFG is written again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tid        <= TID_INIT;
      tcfg       <= 32'h0;
      tval       <= 32'h0;
      timer_stop <= 1'b0;
      timer_int  <= 1'b0;
    end else begin
      if (we_tid) begin
        tid <= wdata;
      end
      if (we_tcfg) begin
        tcfg       <= wdata;
        tval       <= {wdata[31:2], 2'b00};
        timer_stop <= 1'b0;
      end else if (tcfg[0] && !timer_stop) begin
        if (tval != 32'h0) begin
          tval <= tval - 32'h1;
        end else if (tcfg[1]) begin
          tval <= {tcfg[31:2], 2'b00};
        end else begin
          tval       <= 32'hffffffff;
          timer_stop <= 1'b1;
        end
      end
      if (timer_fire) begin
        timer_int <= 1'b1;
      end else if (ticlr_clr) begin
        timer_int <= 1'b0;
      end
    end
  end
`else
  logic unused_tid_init;
  assign unused_tid_init = ^TID_INIT;
  assign timer_int       = 1'b0;
`endif

  assign bus.has_int    = (|(estat_is & ecfg_lie)) & crmd_ie;
  assign bus.ex_entry   = {eentry_va, 6'h0};
  assign bus.ertn_entry = era;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - scoreboard bench for csr_file (timer checks follow CSR_TIMER_EN)
module tb_csr_file;
  localparam logic [31:0] EENTRY_INIT = 32'h1c008000;
  localparam logic [31:0] ESTAT_BASE  = 32'h00010003;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_q [$];

  csr_file_if bus ();

  csr_file #(
    .TID_INIT    (32'h0),
    .EENTRY_INIT (EENTRY_INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  task automatic expect_rd(input string tag, input logic [13:0] num, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus.csr_re  = 1'b1;
    bus.csr_num = num;
    #1;
    cmp_pop(tag, bus.csr_rvalue);
    bus.csr_re  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    @(negedge clk);
    bus.csr_we     = 1'b1;
    bus.csr_num    = num;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    step();
    bus.csr_we = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    reset    = 1'b1;
    bus.csr_re = 1'b0; bus.csr_num = 14'h0; bus.csr_we = 1'b0;
    bus.csr_wmask = 32'h0; bus.csr_wvalue = 32'h0;
    bus.wb_ex = 1'b0; bus.wb_ecode = 6'h0; bus.wb_esubcode = 9'h0; bus.wb_pc = 32'h0;
    bus.ertn_flush = 1'b0; bus.hw_int_in = 8'h0; bus.ipi_int_in = 1'b0;
    #1;
    expect_rd("rst_crmd", 14'h0, 32'h8);
    expect_rd("rst_eentry", 14'hc, EENTRY_INIT);
    expect_rd("rst_era", 14'h6, 32'h0);
    exp_q.push_back(32'h0);
    cmp_pop("rst_has_int", {31'h0, bus.has_int});
    exp_q.push_back(EENTRY_INIT);
    cmp_pop("rst_ex_entry", bus.ex_entry);
    #11;
    reset = 1'b0;
    bus.csr_num = 14'h0;
    #1;
    exp_q.push_back(32'h0);
    cmp_pop("re_low_reads_0", bus.csr_rvalue);

    // masked write, then exception
    wr(14'h0, 32'h4, 32'h7);
    expect_rd("crmd_masked", 14'h0, 32'hc);
    @(negedge clk);
    bus.wb_ex = 1'b1; bus.wb_ecode = 6'hb; bus.wb_esubcode = 9'h3; bus.wb_pc = 32'h1c000100;
    step();
    bus.wb_ex = 1'b0;
    expect_rd("ex_era", 14'h6, 32'h1c000100);
    expect_rd("ex_estat", 14'h5, 32'h00cb0000);
    expect_rd("ex_crmd", 14'h0, 32'h8);
    expect_rd("ex_prmd", 14'h1, 32'h4);
    exp_q.push_back(32'h1c000100);
    cmp_pop("ertn_entry", bus.ertn_entry);

    // exception beats same-cycle CRMD write on PLV/IE, DA write still lands
    wr(14'h0, 32'h7, 32'h5);
    expect_rd("crmd_plv1_ie1", 14'h0, 32'hd);
    @(negedge clk);
    bus.wb_ex = 1'b1; bus.wb_ecode = 6'h1; bus.wb_esubcode = 9'h0; bus.wb_pc = 32'h1c000200;
    bus.csr_we = 1'b1; bus.csr_num = 14'h0; bus.csr_wmask = 32'hf; bus.csr_wvalue = 32'h7;
    step();
    bus.wb_ex = 1'b0; bus.csr_we = 1'b0;
    expect_rd("exwe_crmd", 14'h0, 32'h0);
    expect_rd("exwe_prmd", 14'h1, 32'h5);
    expect_rd("exwe_estat", 14'h5, 32'h00010000);
    // ertn beats same-cycle write on IE, DA write lands
    @(negedge clk);
    bus.ertn_flush = 1'b1;
    bus.csr_we = 1'b1; bus.csr_num = 14'h0; bus.csr_wmask = 32'hc; bus.csr_wvalue = 32'h8;
    step();
    bus.ertn_flush = 1'b0; bus.csr_we = 1'b0;
    expect_rd("ertn_crmd", 14'h0, 32'hd);

    // interrupts
    wr(14'h4, 32'hffffffff, 32'hffffffff);
    expect_rd("ecfg_bit10_ro", 14'h4, 32'h00001bff);
    wr(14'h4, 32'hffffffff, 32'h4);
    expect_rd("ecfg_lie", 14'h4, 32'h4);
    @(negedge clk);
    bus.hw_int_in = 8'h01;
    exp_q.push_back(32'h0);
    #1;
    cmp_pop("int_not_yet", {31'h0, bus.has_int});
    exp_q.push_back(32'h1);
    step();
    cmp_pop("int_on", {31'h0, bus.has_int});
    expect_rd("int_estat", 14'h5, 32'h00010004);
    @(negedge clk);
    bus.hw_int_in = 8'h00;
    exp_q.push_back(32'h0);
    step();
    cmp_pop("int_off", {31'h0, bus.has_int});
    @(negedge clk);
    bus.ipi_int_in = 1'b1;
    exp_q.push_back(32'h0);
    step();
    cmp_pop("ipi_masked", {31'h0, bus.has_int});
    wr(14'h5, 32'hffffffff, 32'hffffffff);
    expect_rd("estat_sw_is", 14'h5, 32'h00011003);
    @(negedge clk);
    bus.ipi_int_in = 1'b0;
    step();
    expect_rd("estat_base", 14'h5, ESTAT_BASE);

    // plain registers and unimplemented space
    wr(14'hc, 32'hffffffff, 32'hffffffff);
    expect_rd("eentry_low0", 14'hc, 32'hffffffc0);
    exp_q.push_back(32'hffffffc0);
    cmp_pop("ex_entry_port", bus.ex_entry);
    wr(14'h32, 32'hffffffff, 32'ha5a5a5a5);
    wr(14'h32, 32'h0000ffff, 32'h0);
    expect_rd("save2_masked", 14'h32, 32'ha5a50000);
    expect_rd("save1_untouched", 14'h31, 32'h0);
    wr(14'h7, 32'hffffffff, 32'hffffffff);
    expect_rd("unimpl_reads_0", 14'h7, 32'h0);

`ifdef CSR_TIMER_EN
    wr(14'h41, 32'hffffffff, 32'h0000000b);
    expect_rd("tval_load", 14'h42, 32'h8);
    for (int k = 7; k >= 0; k--) begin
      step();
      expect_rd($sformatf("tval_%0d", k), 14'h42, k);
    end
    step();
    expect_rd("tval_reload", 14'h42, 32'h8);
    expect_rd("timer_is11", 14'h5, ESTAT_BASE | 32'h800);
    wr(14'h41, 32'hffffffff, 32'h0);
    wr(14'h44, 32'hffffffff, 32'h1);
    expect_rd("ticlr_clear", 14'h5, ESTAT_BASE);
    expect_rd("ticlr_reads_0", 14'h44, 32'h0);
    // fire and clear in the same cycle: set wins
    wr(14'h41, 32'hffffffff, 32'h3);
    wr(14'h44, 32'hffffffff, 32'h1);
    expect_rd("set_wins", 14'h5, ESTAT_BASE | 32'h800);
    wr(14'h41, 32'hffffffff, 32'h0);
    wr(14'h44, 32'hffffffff, 32'h1);
    expect_rd("clear_after", 14'h5, ESTAT_BASE);
    // one-shot
    wr(14'h41, 32'hffffffff, 32'h9);
    repeat (8) step();
    expect_rd("oneshot_zero", 14'h42, 32'h0);
    step();
    expect_rd("oneshot_fire", 14'h42, 32'hffffffff);
    expect_rd("oneshot_is11", 14'h5, ESTAT_BASE | 32'h800);
    step();
    expect_rd("oneshot_hold", 14'h42, 32'hffffffff);
    wr(14'h41, 32'hffffffff, 32'h9);
    step();
    expect_rd("restart_7", 14'h42, 32'h7);
`else
    wr(14'h41, 32'hffffffff, 32'h0000000b);
    repeat (3) step();
    expect_rd("notimer_tcfg", 14'h41, 32'h0);
    expect_rd("notimer_tval", 14'h42, 32'h0);
    repeat (8) step();
    expect_rd("notimer_is11", 14'h5, ESTAT_BASE);
`endif

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    expect_rd("arst_tval", 14'h42, 32'h0);
    expect_rd("arst_estat", 14'h5, 32'h0);
    expect_rd("arst_crmd", 14'h0, 32'h8);
    expect_rd("arst_era", 14'h6, 32'h0);
    #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
